answer_checker: RTL and testbench

Downstream consumer of the expression generator. It captures the generator's `result` when `gen_done` rises and collects the player's decimal answer from keypad events. When the player presses enter or the answer times out, it compares the answer against the captured result. It then reports correct or wrong, maintains the score, and drives the `level` input that the generator uses to select the operator.

---
 rtl/calc_pkg.sv | 25 ++
 rtl/digit_accumulator.sv | 30 +++
 rtl/answer_checker.sv | 151 +++++++++++++++
 tb/tb_answer_checker.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator game blocks:
// key codes, operator codes, level bounds and checker states.
package calc_pkg;

  localparam logic [4:0] KEY_CLEAR = 5'd14;
  localparam logic [4:0] KEY_ENTER = 5'd15;

  localparam logic [4:0] OP_ADD = 5'd11;
  localparam logic [4:0] OP_SUB = 5'd12;
  localparam logic [4:0] OP_MUL = 5'd13;

  localparam logic [2:0] LEVEL_MIN = 3'd1;
  localparam logic [2:0] LEVEL_MAX = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK
  } chk_state_t;

  function automatic logic is_digit(logic [4:0] code);
    return code <= 5'd9;
  endfunction

endpackage

// File: rtl/digit_accumulator.sv
// Decimal answer entry: up to three digits, value plus
// a 5-bit-per-digit display shift register.
module digit_accumulator (
  input  logic        tick,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        dig_stb,
  input  logic [3:0]  dig,
  output logic [9:0]  value,
  output logic [14:0] entry,
  output logic [1:0]  count
);

  always_ff @(posedge tick) begin
    if (!rst_n) begin
      value <= '0;
      entry <= '0;
      count <= '0;
    end else if (clr) begin
      value <= '0;
      entry <= '0;
      count <= '0;
    end else if (dig_stb && count != 2'd3) begin
      value <= 10'(value * 10) + {6'd0, dig};
      entry <= {entry[9:0], 1'b0, dig};
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/answer_checker.sv
// Captures the generated result, collects the keyed answer,
// issues a verdict and tracks score, streak and level.
module answer_checker
  import calc_pkg::*;
#(
  parameter int TIMEOUT_TICKS  = 1000,
  parameter int LEVEL_UP_SCORE = 5
) (
  input  logic        tick,
  input  logic        rst_n,
  input  logic        gen_done,
  input  logic [9:0]  result,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  output logic [14:0] entry,
  output logic        answer_done,
  output logic        correct,
  output logic        timed_out,
  output logic [7:0]  score,
  output logic [2:0]  level
);

  localparam int TW = $clog2(TIMEOUT_TICKS);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_TICKS - 1);
  localparam int SW = $clog2(LEVEL_UP_SCORE + 1);
  localparam logic [SW-1:0] S_LAST = SW'(LEVEL_UP_SCORE - 1);

  chk_state_t state, nstate;

  logic          gen_q;
  logic [9:0]    res_q;
  logic [TW-1:0] tmo_cnt;
  logic          to_flag;
  logic [SW-1:0] streak;

  logic          acc_clr;
  logic          dig_stb;
  logic          capture;
  logic          verdict;
  logic          go_to;
  logic [9:0]    value;
  logic [1:0]    count;

  logic key_dig;
  logic key_clr;
  logic enter_ok;
  logic expire;
  logic win;

  assign key_dig  = key_valid && is_digit(key_code);
  assign key_clr  = key_valid && key_code == KEY_CLEAR;
  assign enter_ok = key_valid && key_code == KEY_ENTER
                 && count != 2'd0;
  assign expire   = tmo_cnt == T_LAST;
  assign win      = !to_flag && value == res_q;

  digit_accumulator u_acc (
    .tick    (tick),
    .rst_n   (rst_n),
    .clr     (acc_clr),
    .dig_stb (dig_stb),
    .dig     (key_code[3:0]),
    .value   (value),
    .entry   (entry),
    .count   (count)
  );

  always_ff @(posedge tick) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate  = state;
    acc_clr = 1'b0;
    dig_stb = 1'b0;
    capture = 1'b0;
    verdict = 1'b0;
    go_to   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        acc_clr = 1'b1;
        if (gen_done && !gen_q) begin
          capture = 1'b1;
          nstate  = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        dig_stb = key_dig;
        acc_clr = key_clr;
        // enter beats expiry on the same tick
        if (enter_ok) begin
          nstate = ST_CHECK;
        end else if (expire) begin
          nstate = ST_CHECK;
          go_to  = 1'b1;
        end
      end
      ST_CHECK: begin
        verdict = 1'b1;
        nstate  = ST_IDLE;
      end
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge tick) begin
    if (!rst_n) begin
      gen_q   <= 1'b0;
      res_q   <= '0;
      tmo_cnt <= '0;
      to_flag <= 1'b0;
    end else begin
      gen_q <= gen_done;
      if (capture) res_q <= result;
      if (state == ST_ENTRY) tmo_cnt <= tmo_cnt + 1'b1;
      else                   tmo_cnt <= '0;
      if (capture)    to_flag <= 1'b0;
      else if (go_to) to_flag <= 1'b1;
    end
  end

  always_ff @(posedge tick) begin
    if (!rst_n) begin
      answer_done <= 1'b0;
      correct     <= 1'b0;
      timed_out   <= 1'b0;
      score       <= '0;
      level       <= LEVEL_MIN;
      streak      <= '0;
    end else begin
      answer_done <= verdict;
      if (verdict) begin
        correct   <= win;
        timed_out <= to_flag;
        if (win) begin
          if (score != 8'hff) score <= score + 8'd1;
          if (streak == S_LAST) begin
            streak <= '0;
            if (level != LEVEL_MAX) level <= level + 3'd1;
          end else begin
            streak <= streak + 1'b1;
          end
        end else begin
          streak <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_answer_checker.sv
// Scoreboard bench for answer_checker: directed and random
// problems against a key-sequence reference model.
module tb_answer_checker;

  localparam int T = 8;
  localparam int L = 5;

  logic        tick;
  logic        rst_n;
  logic        gen_done;
  logic [9:0]  result;
  logic        key_valid;
  logic [4:0]  key_code;
  logic [14:0] entry;
  logic        answer_done;
  logic        correct;
  logic        timed_out;
  logic [7:0]  score;
  logic [2:0]  level;

  answer_checker #(
    .TIMEOUT_TICKS  (T),
    .LEVEL_UP_SCORE (L)
  ) dut (
    .tick        (tick),
    .rst_n       (rst_n),
    .gen_done    (gen_done),
    .result      (result),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .entry       (entry),
    .answer_done (answer_done),
    .correct     (correct),
    .timed_out   (timed_out),
    .score       (score),
    .level       (level)
  );

  typedef struct {
    int c;
    int to;
    int sc;
    int lv;
    int en;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   seq[$];
  bit   kv[T];
  int   kc[T];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int m_score = 0;
  int m_streak = 0;
  int m_level = 1;

  initial tick = 1'b0;
  always #5 tick = ~tick;
  always @(posedge tick) cyc++;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge tick) begin
    if (rst_n && answer_done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_answer_done at cycle %0d", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("verdict_cycle", cyc, mon_e.cyc);
        chk("correct", int'(correct), mon_e.c);
        chk("timed_out", int'(timed_out), mon_e.to);
        chk("score", int'(score), mon_e.sc);
        chk("level", int'(level), mon_e.lv);
        chk("entry", int'(entry), mon_e.en);
      end
    end
  end

  task automatic push_num(int v);
    if (v >= 100) seq.push_back(v / 100);
    if (v >= 10)  seq.push_back((v / 10) % 10);
    seq.push_back(v % 10);
  endtask

  // lay seq onto entry-tick slots; only enter may use the last slot
  task automatic place(bit gaps);
    int p;
    p = 0;
    for (int i = 0; i < T; i++) begin
      kv[i] = 1'b0;
      kc[i] = 0;
    end
    for (int j = 0; j < seq.size(); j++) begin
      if (gaps && p + (seq.size() - j) <= T - 2
          && $urandom_range(0, 1) == 1)
        p++;
      if (p < T) begin
        kv[p] = 1'b1;
        kc[p] = seq[j];
        p++;
      end
    end
  endtask

  task automatic run_problem(int res);
    int   n0;
    int   term;
    int   to;
    int   val;
    int   en;
    int   ds[$];
    exp_t e;
    term = T - 1;
    to   = 1;
    for (int i = 0; i < T; i++) begin
      if (kv[i]) begin
        if (kc[i] <= 9) begin
          if (ds.size() < 3) ds.push_back(kc[i]);
        end else if (kc[i] == 14) begin
          ds.delete();
        end else if (kc[i] == 15 && ds.size() > 0) begin
          term = i;
          to   = 0;
          break;
        end
      end
    end
    val = 0;
    en  = 0;
    foreach (ds[j]) begin
      val = val * 10 + ds[j];
      en  = en * 32 + ds[j];
    end
    e.c  = (to == 0 && val == res) ? 1 : 0;
    e.to = to;
    if (e.c == 1) begin
      if (m_score < 255) m_score++;
      m_streak++;
      if (m_streak == L) begin
        m_streak = 0;
        if (m_level < 3) m_level++;
      end
    end else begin
      m_streak = 0;
    end
    e.sc = m_score;
    e.lv = m_level;
    e.en = en;

    @(negedge tick);
    gen_done = 1'b1;
    result   = 10'(res);
    @(negedge tick);
    n0 = cyc;
    e.cyc = n0 + term + 2;
    q.push_back(e);
    for (int i = 0; i < T; i++) begin
      key_valid = kv[i];
      key_code  = 5'(kc[i]);
      @(negedge tick);
    end
    key_valid = 1'b0;
    key_code  = 5'd0;
    repeat ($urandom_range(1, 12)) @(negedge tick);
    gen_done = 1'b0;
    repeat (2) @(negedge tick);
  endtask

  task automatic random_problem(int force_mode);
    int mode;
    int res;
    int w;
    mode = (force_mode >= 0) ? force_mode : $urandom_range(0, 9);
    res  = $urandom_range(0, 961);
    seq.delete();
    if (mode <= 5) begin
      if ($urandom_range(0, 3) == 0) begin
        seq.push_back($urandom_range(0, 9));
        seq.push_back(14);
      end
      push_num(res);
      seq.push_back(15);
    end else if (mode == 6) begin
      w = (res + 1 + $urandom_range(0, 50)) % 1000;
      push_num(w);
      if ($urandom_range(0, 1) == 1) seq.push_back(11);
      seq.push_back(15);
    end else if (mode == 7) begin
      push_num($urandom_range(0, 999));
    end else begin
      res = $urandom_range(100, 961);
      push_num(res);
      seq.push_back($urandom_range(0, 9));
      seq.push_back(15);
    end
    place(1'b1);
    run_problem(res);
  endtask

  initial begin
    rst_n     = 1'b0;
    gen_done  = 1'b0;
    result    = '0;
    key_valid = 1'b0;
    key_code  = '0;
    repeat (3) @(negedge tick);
    rst_n = 1'b1;
    @(negedge tick);
    chk("rst_entry", int'(entry), 0);
    chk("rst_answer_done", int'(answer_done), 0);
    chk("rst_correct", int'(correct), 0);
    chk("rst_timed_out", int'(timed_out), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_level", int'(level), 1);

    seq = '{4, 2, 15};
    place(1'b0);
    run_problem(42);
    seq = '{9, 6, 0, 15};
    place(1'b0);
    run_problem(961);
    seq.delete();
    place(1'b0);
    run_problem(100);
    seq = '{1, 2, 3, 4, 15};
    place(1'b0);
    run_problem(123);
    seq = '{14, 15};
    place(1'b0);
    run_problem(5);

    for (int i = 0; i < 15; i++) random_problem(0);
    random_problem(6);
    for (int i = 0; i < 60; i++) random_problem(-1);

    @(negedge tick);
    gen_done = 1'b1;
    result   = 10'd5;
    @(negedge tick);
    key_valid = 1'b1;
    key_code  = 5'd7;
    @(negedge tick);
    key_valid = 1'b0;
    rst_n     = 1'b0;
    gen_done  = 1'b0;
    @(negedge tick);
    chk("midrst_entry", int'(entry), 0);
    chk("midrst_answer_done", int'(answer_done), 0);
    chk("midrst_correct", int'(correct), 0);
    chk("midrst_timed_out", int'(timed_out), 0);
    chk("midrst_score", int'(score), 0);
    chk("midrst_level", int'(level), 1);
    m_score  = 0;
    m_streak = 0;
    m_level  = 1;
    rst_n = 1'b1;
    repeat (10) @(negedge tick);

    seq = '{7, 15};
    place(1'b0);
    run_problem(7);

    repeat (10) @(negedge tick);
    chk("pending_verdicts", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule
